// File: rtl/flash_test_seq.sv
`timescale 1ns/1ps
// flash_test_seq: runs a one-sector self-test through the SPI flash engine
// (ID, WREN, erase, poll, WREN, program, poll, read-back) and reports the result.
//
// state  | meaning
// IDLE   | waiting for start, results held
// RD_ID  | read device ID, capture two bytes
// WREN1  | write enable ahead of erase
// ERASE  | sector erase at TEST_ADDR
// POLL1  | RDSR until WIP clear or POLL_MAX reached
// WREN2  | write enable ahead of program
// PROG   | 256-byte page program at TEST_ADDR
// POLL2  | RDSR until WIP clear or POLL_MAX reached
// READ   | 256-byte read-back, count mismatches
// FINISH | publish pass/fail, pulse test_done
module flash_test_seq #(
  parameter logic [23:0] TEST_ADDR = 24'h000000,
  parameter logic [23:0] POLL_MAX  = 24'd2000000
) (
  input  logic        clock25M,
  input  logic        flash_rst,
  input  logic        start,
  output logic        busy,
  output logic        test_done,
  output logic        test_pass,
  output logic        timeout,
  output logic [8:0]  err_cnt,
  output logic [15:0] dev_id,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  input  logic        spi_done,
  input  logic [7:0]  spi_data,
  input  logic        spi_valid
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_RD_ID  = 4'd1;
  localparam logic [3:0] S_WREN1  = 4'd2;
  localparam logic [3:0] S_ERASE  = 4'd3;
  localparam logic [3:0] S_POLL1  = 4'd4;
  localparam logic [3:0] S_WREN2  = 4'd5;
  localparam logic [3:0] S_PROG   = 4'd6;
  localparam logic [3:0] S_POLL2  = 4'd7;
  localparam logic [3:0] S_READ   = 4'd8;
  localparam logic [3:0] S_FINISH = 4'd9;

  localparam logic [2:0] OP_ID    = 3'b000;
  localparam logic [2:0] OP_WREN  = 3'b001;
  localparam logic [2:0] OP_ERASE = 3'b010;
  localparam logic [2:0] OP_RDSR  = 3'b011;
  localparam logic [2:0] OP_PROG  = 3'b101;
  localparam logic [2:0] OP_READ  = 3'b111;

  logic [3:0]  state;
  logic [1:0]  id_cnt;
  logic [23:0] poll_cnt;
  logic        st_seen;
  logic        st_bit0;
  logic [8:0]  byte_idx;

  logic        req;
  logic [2:0]  op_code;
  logic [7:0]  op_cmd;
  logic [23:0] op_addr;
  logic        status_busy;
  logic        poll_exhausted;
  logic        rd_hit;
  logic        rd_err;
  logic [8:0]  idx_next;
  logic [8:0]  err_next;
  logic [8:0]  err_final;

  assign req = cmd_type[3];

  // Op code, SPI opcode and address belonging to the current state
  always_comb begin
    op_code = OP_ID;
    op_cmd  = 8'h90;
    op_addr = 24'h000000;
    case (state)
      S_WREN1, S_WREN2: begin op_code = OP_WREN;  op_cmd = 8'h06; end
      S_ERASE: begin op_code = OP_ERASE; op_cmd = 8'h20; op_addr = TEST_ADDR; end
      S_POLL1, S_POLL2: begin op_code = OP_RDSR;  op_cmd = 8'h05; end
      S_PROG:  begin op_code = OP_PROG;  op_cmd = 8'h02; op_addr = TEST_ADDR; end
      S_READ:  begin op_code = OP_READ;  op_cmd = 8'h03; op_addr = TEST_ADDR; end
      default: begin op_code = OP_ID;    op_cmd = 8'h90; end
    endcase
  end

  // Status decision and read-back tallies for the current cycle; a byte arriving
  // on the same edge as spi_done is folded in before the decision is made
  always_comb begin
    status_busy    = spi_valid ? spi_data[0] : (st_seen ? st_bit0 : 1'b1);
    poll_exhausted = ({1'b0, poll_cnt} + 25'd1) >= {1'b0, POLL_MAX};
    rd_hit         = req && spi_valid && !byte_idx[8];
    rd_err         = rd_hit && (spi_data != byte_idx[7:0]);
    idx_next       = byte_idx + {8'd0, rd_hit};
    err_next       = err_cnt + {8'd0, rd_err};
    err_final      = err_next + (9'd256 - idx_next);
  end

  // Sequencer, engine request handshake and result registers
  always_ff @(posedge clock25M or posedge flash_rst) begin
    if (flash_rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      test_done  <= 1'b0;
      test_pass  <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= 9'd0;
      dev_id     <= 16'h0000;
      cmd_type   <= 4'h0;
      flash_cmd  <= 8'h00;
      flash_addr <= 24'h000000;
      id_cnt     <= 2'd0;
      poll_cnt   <= 24'd0;
      st_seen    <= 1'b0;
      st_bit0    <= 1'b0;
      byte_idx   <= 9'd0;
    end else begin
      test_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            test_pass <= 1'b0;
            timeout   <= 1'b0;
            err_cnt   <= 9'd0;
            dev_id    <= 16'h0000;
            id_cnt    <= 2'd0;
            poll_cnt  <= 24'd0;
            byte_idx  <= 9'd0;
            state     <= S_RD_ID;
          end
        end
        S_FINISH: begin
          test_pass <= !timeout && (err_cnt == 9'd0);
          test_done <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        S_RD_ID, S_WREN1, S_ERASE, S_POLL1, S_WREN2, S_PROG, S_POLL2, S_READ: begin
          if (!req) begin
            // request line was low for at least this cycle; raise it now
            cmd_type   <= {1'b1, op_code};
            flash_cmd  <= op_cmd;
            flash_addr <= op_addr;
            st_seen    <= 1'b0;
            st_bit0    <= 1'b0;
          end else begin
            if (spi_valid) begin
              case (state)
                S_RD_ID: begin
                  if (id_cnt == 2'd0) begin
                    dev_id[15:8] <= spi_data;
                    id_cnt       <= 2'd1;
                  end else if (id_cnt == 2'd1) begin
                    dev_id[7:0] <= spi_data;
                    id_cnt      <= 2'd2;
                  end
                end
                S_POLL1, S_POLL2: begin
                  st_seen <= 1'b1;
                  st_bit0 <= spi_data[0];
                end
                default: ;
              endcase
            end
            if (state == S_READ) begin
              byte_idx <= idx_next;
              err_cnt  <= err_next;
            end
            if (spi_done) begin
              cmd_type[3] <= 1'b0;
              case (state)
                S_RD_ID: state <= S_WREN1;
                S_WREN1: state <= S_ERASE;
                S_ERASE: begin
                  state    <= S_POLL1;
                  poll_cnt <= 24'd0;
                end
                S_WREN2: state <= S_PROG;
                S_PROG: begin
                  state    <= S_POLL2;
                  poll_cnt <= 24'd0;
                end
                S_POLL1, S_POLL2: begin
                  if (!status_busy) begin
                    state <= (state == S_POLL1) ? S_WREN2 : S_READ;
                  end else if (poll_exhausted) begin
                    timeout <= 1'b1;
                    state   <= S_FINISH;
                  end else begin
                    // stay put; the request is re-raised next cycle
                    poll_cnt <= poll_cnt + 24'd1;
                  end
                end
                S_READ: begin
                  err_cnt <= err_final;
                  state   <= S_FINISH;
                end
                default: ;
              endcase
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_test_seq.sv
`timescale 1ns/1ps
// tb_flash_test_seq: flash-engine model plus scenario table, random scenarios
// and hand-written reset / re-start sequences for flash_test_seq.
module tb_flash_test_seq;

  localparam logic [23:0] TA = 24'h01F000;
  localparam int PM = 8;

  logic        clock25M;
  logic        flash_rst;
  logic        start;
  logic        busy;
  logic        test_done;
  logic        test_pass;
  logic        timeout;
  logic [8:0]  err_cnt;
  logic [15:0] dev_id;
  logic [3:0]  cmd_type;
  logic [7:0]  flash_cmd;
  logic [23:0] flash_addr;
  logic        spi_done;
  logic [7:0]  spi_data;
  logic        spi_valid;

  flash_test_seq #(.TEST_ADDR(TA), .POLL_MAX(24'd8)) dut (
    .clock25M   (clock25M),
    .flash_rst  (flash_rst),
    .start      (start),
    .busy       (busy),
    .test_done  (test_done),
    .test_pass  (test_pass),
    .timeout    (timeout),
    .err_cnt    (err_cnt),
    .dev_id     (dev_id),
    .cmd_type   (cmd_type),
    .flash_cmd  (flash_cmd),
    .flash_addr (flash_addr),
    .spi_done   (spi_done),
    .spi_data   (spi_data),
    .spi_valid  (spi_valid)
  );

  initial clock25M = 1'b0;
  always #20 clock25M = ~clock25M;

  int n_checks;
  int n_err;

  // flash model configuration
  logic [15:0] m_id;
  int m_eb, m_pb, m_nb, m_ca, m_cb;
  bit m_nobyte;
  int busy_left;

  logic [2:0]  log_op[$];
  logic [7:0]  log_cmd[$];
  logic [23:0] log_addr[$];
  logic [2:0]  exp_ops[$];
  int td_cnt;

  typedef struct {
    logic [15:0] id;
    int eb, pb, nb, ca, cb;
    logic [15:0] x_id;
    int x_err;
    bit x_pass, x_to;
    int x_ops;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_cmd(input logic [2:0] op);
    case (op)
      3'b000: return 8'h90;
      3'b001: return 8'h06;
      3'b010: return 8'h20;
      3'b011: return 8'h05;
      3'b101: return 8'h02;
      3'b111: return 8'h03;
      default: return 8'hxx;
    endcase
  endfunction

  // ---------------- engine model ----------------
  task automatic eng_tick(output bit ab);
    @(posedge clock25M); #1;
    ab = (flash_rst !== 1'b0);
  endtask

  task automatic put_byte(input logic [7:0] b, output bit ab);
    spi_valid = 1'b1;
    spi_data  = b;
    eng_tick(ab);
    spi_valid = 1'b0;
    if (!ab && $urandom_range(0, 3) == 0) eng_tick(ab);
  endtask

  task automatic serve(input logic [2:0] op);
    bit ab;
    bit isb;
    logic [7:0] b;
    ab = 1'b0;
    repeat (2) begin
      eng_tick(ab);
      if (ab) return;
    end
    case (op)
      3'b000: begin
        for (int i = 0; i < 3; i++) begin
          b = (i == 0) ? m_id[15:8] : (i == 1) ? m_id[7:0] : 8'hAA;
          put_byte(b, ab);
          if (ab) return;
        end
      end
      3'b011: begin
        isb = (busy_left > 0);
        if (isb) busy_left--;
        b = 8'($urandom);
        b[0] = isb;
        if (!(isb && m_nobyte && $urandom_range(0, 2) == 0)) begin
          put_byte(b, ab);
          if (ab) return;
        end
      end
      3'b010: busy_left = m_eb;
      3'b101: busy_left = m_pb;
      3'b111: begin
        for (int i = 0; i < m_nb; i++) begin
          b = 8'(i);
          if (i == m_ca || i == m_cb) b = b ^ 8'h5A;
          put_byte(b, ab);
          if (ab) return;
        end
      end
      default: ;
    endcase
    spi_done = 1'b1;
    eng_tick(ab);
    spi_done = 1'b0;
  endtask

  initial begin
    spi_done = 1'b0;
    spi_valid = 1'b0;
    spi_data = 8'h00;
    forever begin
      @(posedge clock25M); #1;
      if (flash_rst === 1'b0 && cmd_type[3] === 1'b1) begin
        log_op.push_back(cmd_type[2:0]);
        log_cmd.push_back(flash_cmd);
        log_addr.push_back(flash_addr);
        serve(cmd_type[2:0]);
      end
    end
  end

  // ---------------- handshake monitor ----------------
  logic p_valid, p_done;
  logic [3:0] p_ct;
  logic [7:0] p_cmd;
  logic [23:0] p_addr;
  initial p_valid = 1'b0;

  always @(negedge clock25M) begin
    if (flash_rst !== 1'b0) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid && p_ct[3]) begin
        if (p_done) chk("req_low_after_done", 64'(cmd_type[3]), 64'd0);
        else chk("req_held_stable", 64'({cmd_type, flash_cmd, flash_addr}), 64'({p_ct, p_cmd, p_addr}));
      end
      if (test_done === 1'b1) begin
        td_cnt++;
        chk("busy_low_with_done", 64'(busy), 64'd0);
      end
      p_ct = cmd_type;
      p_cmd = flash_cmd;
      p_addr = flash_addr;
      p_done = spi_done;
      p_valid = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  task automatic ref_model(input int eb, input int pb, input int nb, input int ca, input int cb,
                           output logic [8:0] e_err, output bit e_pass, output bit e_to);
    int got, cnt;
    exp_ops.delete();
    e_to = 1'b0;
    cnt = 0;
    exp_ops.push_back(3'b000);
    exp_ops.push_back(3'b001);
    exp_ops.push_back(3'b010);
    if (eb >= PM) begin
      repeat (PM) exp_ops.push_back(3'b011);
      e_to = 1'b1;
    end else begin
      repeat (eb + 1) exp_ops.push_back(3'b011);
      exp_ops.push_back(3'b001);
      exp_ops.push_back(3'b101);
      if (pb >= PM) begin
        repeat (PM) exp_ops.push_back(3'b011);
        e_to = 1'b1;
      end else begin
        repeat (pb + 1) exp_ops.push_back(3'b011);
        exp_ops.push_back(3'b111);
        got = (nb < 256) ? nb : 256;
        for (int i = 0; i < got; i++) if (i == ca || i == cb) cnt++;
        cnt += 256 - got;
      end
    end
    e_err = 9'(cnt);
    e_pass = !e_to && (cnt == 0);
  endtask

  task automatic pulse_start();
    @(posedge clock25M); #1;
    start = 1'b1;
    @(posedge clock25M); #1;
    start = 1'b0;
  endtask

  task automatic run_test(input string tag, input logic [15:0] id, input int eb, input int pb,
                          input int nb, input int ca, input int cb, input bit nobyte, input bit dbl,
                          output logic [15:0] a_id, output logic [8:0] a_err,
                          output bit a_pass, output bit a_to, output int a_ops);
    logic [8:0] e_err;
    bit e_pass, e_to, seen;
    int bad, bad2, n;
    m_id = id; m_eb = eb; m_pb = pb; m_nb = nb; m_ca = ca; m_cb = cb;
    m_nobyte = nobyte;
    busy_left = 0;
    ref_model(eb, pb, nb, ca, cb, e_err, e_pass, e_to);
    log_op.delete(); log_cmd.delete(); log_addr.delete();
    td_cnt = 0;
    pulse_start();
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    chk({tag, "_cleared_on_start"}, 64'({test_pass, timeout, err_cnt, dev_id}), 64'd0);
    if (dbl) begin
      repeat (10) @(posedge clock25M);
      #1;
      chk({tag, "_busy_before_2nd_start"}, 64'(busy), 64'd1);
      start = 1'b1;
      @(posedge clock25M); #1;
      start = 1'b0;
    end
    seen = 1'b0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      @(negedge clock25M);
      if (test_done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_test_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_dev_id"}, 64'(dev_id), 64'(id));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
    chk({tag, "_test_pass"}, 64'(test_pass), 64'(e_pass));
    chk({tag, "_timeout"}, 64'(timeout), 64'(e_to));
    chk({tag, "_op_count"}, 64'(log_op.size()), 64'(exp_ops.size()));
    bad = 0;
    bad2 = 0;
    n = (log_op.size() < exp_ops.size()) ? log_op.size() : exp_ops.size();
    for (int i = 0; i < n; i++) if (log_op[i] !== exp_ops[i]) bad++;
    for (int i = 0; i < log_op.size(); i++) begin
      if (log_cmd[i] !== exp_cmd(log_op[i])) bad2++;
      if (log_op[i] == 3'b000 && log_addr[i] !== 24'h000000) bad2++;
      if ((log_op[i] == 3'b010 || log_op[i] == 3'b101 || log_op[i] == 3'b111) && log_addr[i] !== TA) bad2++;
    end
    chk({tag, "_op_sequence_bad"}, 64'(bad), 64'd0);
    chk({tag, "_op_cmd_addr_bad"}, 64'(bad2), 64'd0);
    a_id = dev_id; a_err = err_cnt; a_pass = test_pass; a_to = timeout; a_ops = log_op.size();
    repeat (3) @(negedge clock25M);
    chk({tag, "_one_done_pulse"}, 64'(td_cnt), 64'd1);
    chk({tag, "_idle_after"}, 64'({busy, cmd_type[3]}), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a_id;
    logic [8:0] a_err;
    bit a_pass, a_to, found;
    int a_ops;
    string tg;
    n_checks = 0;
    n_err = 0;
    td_cnt = 0;
    flash_rst = 1'b1;
    start = 1'b0;

    //           id       eb   pb  nb   ca   cb   x_id      err  pass to ops
    vt[0] = '{16'hEF17,   3,   2, 256,  -1,  -1, 16'hEF17,   0, 1, 0, 13};
    vt[1] = '{16'hEF17,   3,   2, 256,   5, 200, 16'hEF17,   2, 0, 0, 13};
    vt[2] = '{16'hEF17,   3,   2, 250,  -1,  -1, 16'hEF17,   6, 0, 0, 13};
    vt[3] = '{16'hC228, 100,   0, 256,  -1,  -1, 16'hC228,   0, 0, 1, 11};
    vt[4] = '{16'h1234,   0,   0, 256, 255,   0, 16'h1234,   2, 0, 0,  8};
    vt[5] = '{16'hABCD,   7,   7, 256,  -1,  -1, 16'hABCD,   0, 1, 0, 22};
    vt[6] = '{16'h5A5A,   1,   1,   0,  -1,  -1, 16'h5A5A, 256, 0, 0, 10};
    vt[7] = '{16'h0001,   2,   0, 260, 258, 257, 16'h0001,   0, 1, 0, 10};
    vt[8] = '{16'hFFFF,   0,   8, 256,  -1,  -1, 16'hFFFF,   0, 0, 1, 14};

    repeat (3) @(negedge clock25M);
    chk("reset_outputs", 64'({busy, test_done, test_pass, timeout, err_cnt, dev_id, cmd_type}), 64'd0);
    chk("reset_cmd_addr", 64'({flash_cmd, flash_addr}), 64'd0);
    flash_rst = 1'b0;
    repeat (2) @(negedge clock25M);

    // stray engine done/valid with nothing outstanding
    spi_done = 1'b1; spi_valid = 1'b1; spi_data = 8'h12;
    @(negedge clock25M);
    spi_done = 1'b0; spi_valid = 1'b0;
    @(negedge clock25M);
    chk("stray_done_ignored", 64'({busy, test_done, cmd_type, dev_id}), 64'd0);

    for (int k = 0; k < 9; k++) begin
      tg = $sformatf("row%0d", k);
      run_test(tg, vt[k].id, vt[k].eb, vt[k].pb, vt[k].nb, vt[k].ca, vt[k].cb, 1'b0, 1'b0,
               a_id, a_err, a_pass, a_to, a_ops);
      chk({tg, "_tab_id"}, 64'(a_id), 64'(vt[k].x_id));
      chk({tg, "_tab_err"}, 64'(a_err), 64'(vt[k].x_err));
      chk({tg, "_tab_pass"}, 64'(a_pass), 64'(vt[k].x_pass));
      chk({tg, "_tab_timeout"}, 64'(a_to), 64'(vt[k].x_to));
      chk({tg, "_tab_ops"}, 64'(a_ops), 64'(vt[k].x_ops));
    end

    for (int k = 0; k < 10; k++) begin
      int eb, pb, nb, ca, cb;
      eb = int'($urandom_range(0, 9));
      pb = int'($urandom_range(0, 9));
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(240, 262)) : 256;
      ca = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 270)) : -1;
      cb = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 270)) : -1;
      run_test($sformatf("rnd%0d", k), 16'($urandom), eb, pb, nb, ca, cb, 1'b1, 1'b0,
               a_id, a_err, a_pass, a_to, a_ops);
    end

    // second start while busy must be ignored
    run_test("dbl_start", 16'hEF17, 3, 2, 256, -1, -1, 1'b0, 1'b1, a_id, a_err, a_pass, a_to, a_ops);
    chk("dbl_start_ops", 64'(a_ops), 64'd13);

    // reset in the middle of PROG
    m_id = 16'hEF17; m_eb = 3; m_pb = 2; m_nb = 256; m_ca = -1; m_cb = -1; m_nobyte = 1'b0;
    busy_left = 0;
    log_op.delete(); log_cmd.delete(); log_addr.delete();
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < 20000 && !found; c++) begin
      @(negedge clock25M);
      if (cmd_type === 4'b1101) found = 1'b1;
    end
    chk("prog_reached", 64'(found), 64'd1);
    #5 flash_rst = 1'b1;
    #1;
    chk("rst_cmd_type", 64'(cmd_type), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outputs", 64'({test_done, test_pass, timeout, err_cnt, dev_id, flash_cmd, flash_addr}), 64'd0);
    repeat (2) @(negedge clock25M);
    flash_rst = 1'b0;
    repeat (2) @(negedge clock25M);
    run_test("after_rst", 16'hEF17, 3, 2, 256, -1, -1, 1'b0, 1'b0, a_id, a_err, a_pass, a_to, a_ops);
    chk("after_rst_pass", 64'(a_pass), 64'd1);
    chk("after_rst_ops", 64'(a_ops), 64'd13);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
